// File: rtl/shift_ctrl.sv
// shift_ctrl: load-then-shift sequencer for a WIDTH-bit shifter chain.
// Captures a parallel value, strobes it into the chain for one cycle, then
// issues WIDTH shift pulses spaced (rate+1) cycles apart and pulses done.
// Every output is driven straight from a flop; output flops are loaded from
// the next-state values so each output lines up with its own state cycle.
module shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] rate,
  input  logic             fill,
  output logic [WIDTH-1:0] load_val,
  output logic             load_n,
  output logic             shift,
  output logic             shift_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_bits;
  logic [CNT_W-1:0] w_bits_nxt;
  logic [WIDTH-1:0] r_load_val;
  logic [WIDTH-1:0] w_load_val_nxt;

  logic r_load_n;
  logic r_shift;
  logic r_shift_in;
  logic r_busy;
  logic r_done;
  logic w_load_n_nxt;
  logic w_shift_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  // State, captured operands and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_period   <= C_ZERO;
      r_cnt      <= C_ZERO;
      r_bits     <= C_ZERO;
      r_load_val <= {WIDTH{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_period   <= w_period_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bits     <= w_bits_nxt;
      r_load_val <= w_load_val_nxt;
    end
  end

  // Next-state and counter sequencing; operands are frozen once accepted
  always_comb begin
    w_state_nxt    = r_state;
    w_period_nxt   = r_period;
    w_cnt_nxt      = r_cnt;
    w_bits_nxt     = r_bits;
    w_load_val_nxt = r_load_val;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_LOAD;
          w_period_nxt   = rate;
          w_load_val_nxt = data_in;
          w_bits_nxt     = C_ZERO;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_SHIFT;
        w_cnt_nxt   = r_period;
      end
      S_SHIFT: begin
        if (r_cnt == C_ZERO) begin
          // This cycle carries a shift pulse: reload spacing, count the bit
          w_cnt_nxt = r_period;
          if (r_bits != C_LAST) begin
            w_bits_nxt = r_bits + C_ONE;
          end else begin
            w_bits_nxt = r_bits;
          end
          if (w_bits_nxt == C_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end else begin
          w_cnt_nxt   = r_cnt - C_ONE;
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs align with it
  always_comb begin
    w_load_n_nxt = 1'b1;
    w_shift_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_load_n_nxt = 1'b1;
      end
      S_LOAD: begin
        w_load_n_nxt = 1'b0;
        w_busy_nxt   = 1'b1;
      end
      S_SHIFT: begin
        w_busy_nxt  = 1'b1;
        w_shift_nxt = (w_cnt_nxt == C_ZERO);
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_load_n_nxt = 1'b1;
      end
    endcase
  end

  // Output flops, including the one-cycle retime of the serial fill bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_n   <= 1'b1;
      r_shift    <= 1'b0;
      r_shift_in <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_load_n   <= w_load_n_nxt;
      r_shift    <= w_shift_nxt;
      r_shift_in <= fill;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign load_val = r_load_val;
  assign load_n   = r_load_n;
  assign shift    = r_shift;
  assign shift_in = r_shift_in;
  assign busy     = r_busy;
  assign done     = r_done;
  assign bit_cnt  = r_bits;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: table of operations plus hand-written
// sequences for reset mid-shift and continuously held start.
module tb_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] rate = 4'h0;
  logic       fill = 1'b0;
  logic [7:0] load_val;
  logic       load_n;
  logic       shift;
  logic       shift_in;
  logic       busy;
  logic       done;
  logic [3:0] bit_cnt;

  int checks = 0;
  int failures = 0;

  shift_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .rate(rate), .fill(fill), .load_val(load_val), .load_n(load_n),
    .shift(shift), .shift_in(shift_in), .busy(busy), .done(done),
    .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] rate;
    int         gap;       // cycles between shift pulses
    int         exp_done;  // cycle of done, LOAD cycle counted as 1
    logic       disturb;   // poke data_in/rate/start during SHIFT
    logic       hold;      // keep start high throughout
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // load_n low and shift high must never coincide
  always @(negedge clk) begin
    if (reset_n) begin
      chk("exclusive", int'(!load_n && shift), 0);
    end
  end

  task automatic run_op(input vec_t v);
    int n;
    int pulses;
    data_in = v.data;
    rate    = v.rate;
    start   = 1'b1;
    @(negedge clk);
    n = 1;
    chk("load_n_low", load_n, 0);
    chk("load_busy", busy, 1);
    chk("load_shift", shift, 0);
    chk("load_val", load_val, v.data);
    chk("load_bitcnt", bit_cnt, 0);
    pulses = 0;
    while (1) begin
      if (!v.hold) start = 1'b0;
      fill = 1'($urandom);
      @(negedge clk);
      n++;
      chk("shift_in", shift_in, fill);
      if (v.hold && n == 2) data_in = ~v.data;
      if (shift) begin
        pulses++;
        chk("pulse_cycle", n, 1 + pulses * v.gap);
        chk("shift_busy", busy, 1);
        if (v.disturb && pulses == 2) begin
          data_in = ~v.data;
          rate    = ~v.rate;
          start   = 1'b1;
        end
      end
      if (done) break;
      if (n > v.exp_done + 5) begin
        chk("done_timeout", n, v.exp_done);
        break;
      end
    end
    chk("done_cycle", n, v.exp_done);
    chk("pulses", pulses, 8);
    chk("done_bitcnt", bit_cnt, 8);
    chk("done_busy", busy, 0);
    chk("done_load_n", load_n, 1);
    chk("held_load_val", load_val, v.data);
    if (!v.hold) begin
      start = 1'b0;
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_bitcnt", bit_cnt, 8);
      chk("idle_busy", busy, 0);
    end
  endtask

  vec_t vecs [5];

  initial begin
    int n;
    vec_t hv;
    vecs[0] = '{data: 8'hA5, rate: 4'd0,  gap: 1,  exp_done: 10,  disturb: 1'b0, hold: 1'b0};
    vecs[1] = '{data: 8'h3C, rate: 4'd3,  gap: 4,  exp_done: 34,  disturb: 1'b0, hold: 1'b0};
    vecs[2] = '{data: 8'h5A, rate: 4'd1,  gap: 2,  exp_done: 18,  disturb: 1'b1, hold: 1'b0};
    vecs[3] = '{data: 8'hFF, rate: 4'd15, gap: 16, exp_done: 130, disturb: 1'b0, hold: 1'b0};
    vecs[4] = '{data: 8'h81, rate: 4'd2,  gap: 3,  exp_done: 26,  disturb: 1'b1, hold: 1'b0};

    // Reset state before any clock edge
    #1 reset_n = 1'b0;
    #1;
    chk("rst_load_n", load_n, 1);
    chk("rst_shift", shift, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bitcnt", bit_cnt, 0);
    chk("rst_load_val", load_val, 0);
    chk("rst_shift_in", shift_in, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset after three shift pulses: immediate clear, no done
    data_in = 8'hC3;
    rate    = 4'd1;
    start   = 1'b1;
    fill    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (shift) n++;
    end
    chk("pre_reset_pulses", n, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_load_n", load_n, 1);
    chk("mid_rst_shift", shift, 0);
    chk("mid_rst_shift_in", shift_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_bitcnt", bit_cnt, 0);
    chk("mid_rst_load_val", load_val, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_hold_done", done, 0);
      chk("rst_hold_busy", busy, 0);
    end
    reset_n = 1'b1;
    fill = 1'b0;
    run_op(vecs[0]);

    // Start held across two operations
    hv = '{data: 8'h11, rate: 4'd0, gap: 1, exp_done: 10, disturb: 1'b0, hold: 1'b1};
    run_op(hv);
    @(negedge clk);
    chk("hold_idle_load_n", load_n, 1);
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_bitcnt", bit_cnt, 8);
    @(negedge clk);
    chk("hold_reload_load_n", load_n, 0);
    chk("hold_reload_val", load_val, 8'hEE);
    chk("hold_reload_bitcnt", bit_cnt, 0);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_second_done", n, 10);
    chk("hold_second_bitcnt", bit_cnt, 8);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): WIDTH, 8, number of shifter bits driven; CNT_W, 4, width of rate and bit_cnt.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a load-then-shift operation.
- data_in  input  WIDTH  parallel value to load.
- rate  input  CNT_W  shift period minus one, in clk cycles.
- fill  input  1  serial bit shifted into the chain head.
- load_val  output  WIDTH  parallel value to the shifter bits.
- load_n  output  1  active-low load strobe to the shifter bits.
- shift  output  1  shift-enable pulse to the shifter bits.
- shift_in  output  1  serial input to the chain head.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- bit_cnt  output  CNT_W  shifts issued in the current operation.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-005 IDLE outputs: load_n=1, shift=0, busy=0, done=0.
REQ-006 IDLE with start=1 at an edge SHALL do all of the following at that edge, then go to LOAD:
- capture data_in into load_val;
- capture rate into an internal period register;
- clear bit_cnt to 0.
REQ-007 LOAD SHALL last exactly one cycle with load_n=0, shift=0, busy=1, then go to SHIFT.
REQ-008 On entry to SHIFT, a down-counter SHALL be loaded with the captured period.
REQ-009 While in SHIFT, busy SHALL be 1 and load_n SHALL be 1.
REQ-010 In SHIFT, shift SHALL be 1 for exactly one cycle whenever the down-counter is 0, and 0 otherwise.
REQ-011 At each shift pulse, the down-counter SHALL reload the period and bit_cnt SHALL increment by one.
REQ-012 After the WIDTH-th shift pulse the FSM SHALL go to DONE; bit_cnt SHALL equal WIDTH and hold that value until the next accepted start.
REQ-013 DONE SHALL last exactly one cycle with done=1, busy=0, shift=0, load_n=1, then go to IDLE.
REQ-014 Timing: with start accepted at edge k, LOAD is cycle k+1, SHIFT spans 8*(rate+1) cycles, and done is asserted in cycle k+2+WIDTH*(rate+1).
REQ-015 rate=0 SHALL produce a shift pulse on every SHIFT cycle; rate=15 SHALL produce one pulse every 16 cycles.
REQ-016 Changes on rate or data_in after acceptance SHALL NOT affect an operation in progress.
REQ-017 start SHALL be ignored in LOAD, SHIFT and DONE; no queuing.
REQ-018 start held high continuously SHALL begin a new operation at the first IDLE edge after DONE.
REQ-019 shift_in SHALL follow fill combinationally-free, i.e. registered each cycle.
REQ-020 load_n=0 and shift=1 SHALL never be asserted in the same cycle.
REQ-021 The down-counter and bit_cnt SHALL not wrap; bit_cnt saturates at WIDTH.

Reset
REQ-022 reset_n=0 SHALL immediately, without a clock edge, force the following values:
- state=IDLE;
- load_val=0, bit_cnt=0, internal counters=0;
- load_n=1, shift=0, shift_in=0, busy=0, done=0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-024 After reset_n returns to 1, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Basic, rate=0: reset, then data_in=8'hA5 with a one-cycle start. Required: load_n low in one cycle; shift high for 8 consecutive cycles; done in the next cycle; bit_cnt=8.
- Slow rate: rate=3, data_in=8'h3C. Required: shift pulses spaced 4 cycles apart; done exactly 2+32 cycles after the start edge.
- Input changes mid-operation: change data_in and rate during SHIFT, and pulse start during SHIFT. Required: load_val unchanged, spacing unchanged, no restart.
- Reset mid-SHIFT: assert reset_n low after 3 shift pulses. Required: outputs go to reset values asynchronously; no done pulse.
- Continuous start: hold start high through two operations. Required: the second LOAD occurs one cycle after DONE (in the IDLE cycle's next edge).
- Exclusivity: check every cycle of all runs. Required: load_n=0 and shift=1 never coincide.
